// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery multiplier controller: state encoding
// and the default operand width with the adder port widths derived from it.
package mont_pkg;

  localparam int N_DEF = 512;
  localparam int N_ADD = N_DEF + 2;
  localparam int N_RES = N_DEF + 3;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ITER   = 4'd1;
  localparam logic [3:0] S_ADD_B  = 4'd2;
  localparam logic [3:0] S_WAIT_B = 4'd3;
  localparam logic [3:0] S_ADD_M  = 4'd4;
  localparam logic [3:0] S_WAIT_M = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_FINAL  = 4'd7;
  localparam logic [3:0] S_WAIT_S = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

endpackage

// File: rtl/mont_iter_cnt.sv
// Iteration counter for the Montgomery bit walk; last is high on iteration N-1.
module mont_iter_cnt #(
  parameter int N = 512,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(N - 1));

endmodule

// File: rtl/mont_mul_ctrl.sv
// Radix-2 Montgomery multiplication sequencer (result = a*b*2^-N mod m) on a shared adder.
// Build option MONT_FINAL_SUB_EN adds the final conditional subtraction of m.
module mont_mul_ctrl
  import mont_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int AW = N + (N_ADD - N_DEF),
  localparam int SW = N + (N_RES - N_DEF),
`ifdef MONT_FINAL_SUB_EN
  localparam int RW = N
`else
  localparam int RW = N + 1
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [RW-1:0] result,
  output logic          done,
  output logic          busy,
  output logic          adder_start,
  output logic          adder_subtract,
  output logic [AW-1:0] adder_in_a,
  output logic [AW-1:0] adder_in_b,
  input  logic [SW-1:0] adder_result,
  input  logic          adder_done,
  output logic [3:0]    state_dbg
);

  // Adder handshake: adder_start pulses once per operation and the next pulse
  // waits for adder_done; operands and subtract hold from the start cycle
  // through the done cycle. adder_done outside the WAIT_* states is ignored.

  logic [3:0]    state, state_next;
  logic [AW-1:0] c;
  logic [N-1:0]  a_sh, b_r, m_r;
  logic [AW-1:0] sum;
  logic          last, skip, cnt_clear, cnt_inc;

  assign sum       = adder_result[AW-1:0];
  assign skip      = (state == S_ITER) && !a_sh[0] && !c[0];
  assign cnt_clear = (state == S_IDLE) && start;
  assign cnt_inc   = skip || (state == S_NEXT);

`ifdef MONT_FINAL_SUB_EN
  logic borrow_free;
  assign borrow_free = adder_result[SW-1];
`else
  logic unused_carry;
  assign unused_carry = adder_result[SW-1];
`endif

  mont_iter_cnt #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ITER;
      S_ITER: begin
        if (a_sh[0])   state_next = S_ADD_B;
        else if (c[0]) state_next = S_ADD_M;
        else           state_next = last ? S_FINAL : S_ITER;
      end
      S_ADD_B:  state_next = S_WAIT_B;
      S_WAIT_B: if (adder_done) state_next = sum[0] ? S_ADD_M : S_NEXT;
      S_ADD_M:  state_next = S_WAIT_M;
      S_WAIT_M: if (adder_done) state_next = S_NEXT;
      S_NEXT:   state_next = last ? S_FINAL : S_ITER;
`ifdef MONT_FINAL_SUB_EN
      S_FINAL:  state_next = S_WAIT_S;
`else
      S_FINAL:  state_next = S_DONE;
`endif
      S_WAIT_S: if (adder_done) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    adder_start    = 1'b0;
    adder_subtract = 1'b0;
    adder_in_b     = '0;
    case (state)
      S_ADD_B: begin
        adder_start = 1'b1;
        adder_in_b  = {2'b00, b_r};
      end
      S_WAIT_B: adder_in_b = {2'b00, b_r};
      S_ADD_M: begin
        adder_start = 1'b1;
        adder_in_b  = {2'b00, m_r};
      end
      S_WAIT_M: adder_in_b = {2'b00, m_r};
`ifdef MONT_FINAL_SUB_EN
      S_FINAL: begin
        adder_start    = 1'b1;
        adder_subtract = 1'b1;
        adder_in_b     = {2'b00, m_r};
      end
      S_WAIT_S: begin
        adder_subtract = 1'b1;
        adder_in_b     = {2'b00, m_r};
      end
`endif
      default: ;
    endcase
    // A reset cycle must never launch an adder operation.
    if (reset) adder_start = 1'b0;
  end

  assign adder_in_a = c;
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      c      <= '0;
      a_sh   <= '0;
      b_r    <= '0;
      m_r    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= in_a;
            b_r  <= in_b;
            m_r  <= in_m;
            c    <= '0;
          end
        end
        S_ITER: begin
          if (skip) begin
            c    <= c >> 1;
            a_sh <= a_sh >> 1;
          end
        end
        // An odd C+b is kept unshifted so the following m addition makes it even.
        S_WAIT_B: if (adder_done) c <= sum[0] ? sum : (sum >> 1);
        S_WAIT_M: if (adder_done) c <= sum >> 1;
        S_NEXT:   a_sh <= a_sh >> 1;
`ifdef MONT_FINAL_SUB_EN
        S_WAIT_S: if (adder_done && borrow_free) c <= sum;
`endif
        S_DONE: begin
          result <= c[RW-1:0];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Self-checking bench for mont_mul_ctrl at N=8, N=4 and N=512 with behavioural adders.
`timescale 1ns/1ps
module tb_mont_mul_ctrl;
  import mont_pkg::*;

`ifdef MONT_FINAL_SUB_EN
  localparam int EXTRA  = 0;
  localparam bit SUB_EN = 1'b1;
`else
  localparam int EXTRA  = 1;
  localparam bit SUB_EN = 1'b0;
`endif
  localparam int BW = 1028;
  typedef logic [BW-1:0] big_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- N = 8 instance ----------------
  logic s8_start, s8_done, s8_busy, s8_ad_start, s8_ad_sub;
  logic s8_ad_done = 1'b0;
  logic [7:0] s8_in_a, s8_in_b, s8_in_m;
  logic [7+EXTRA:0] s8_result;
  logic [9:0] s8_ad_a, s8_ad_b;
  logic [10:0] s8_ad_res = '0;
  logic [3:0] s8_state;

  mont_mul_ctrl #(.N(8)) u8 (
    .clk(clk), .reset(rst), .start(s8_start), .in_a(s8_in_a), .in_b(s8_in_b), .in_m(s8_in_m),
    .result(s8_result), .done(s8_done), .busy(s8_busy), .adder_start(s8_ad_start),
    .adder_subtract(s8_ad_sub), .adder_in_a(s8_ad_a), .adder_in_b(s8_ad_b),
    .adder_result(s8_ad_res), .adder_done(s8_ad_done), .state_dbg(s8_state));

  int cnt8 = 0, starts8 = 0, dones8 = 0, stab8 = 0, ovl8 = 0;
  logic [9:0] hold_a8, hold_b8;
  logic hold_s8;
  always @(posedge clk) begin
    s8_ad_done <= 1'b0;
    if (s8_done) dones8 <= dones8 + 1;
    if (rst) cnt8 <= 0;
    else if (cnt8 > 0) begin
      if (s8_ad_a !== hold_a8 || s8_ad_b !== hold_b8 || s8_ad_sub !== hold_s8) stab8 <= stab8 + 1;
      if (s8_ad_start) ovl8 <= ovl8 + 1;
      if (cnt8 == 2) begin
        s8_ad_done <= 1'b1;
        s8_ad_res  <= s8_ad_sub ? ({1'b0, s8_ad_a} + {1'b0, ~s8_ad_b} + 11'd1)
                                : ({1'b0, s8_ad_a} + {1'b0, s8_ad_b});
      end
      cnt8 <= cnt8 - 1;
    end else if (s8_ad_start) begin
      cnt8 <= 4 + 1; starts8 <= starts8 + 1;
      hold_a8 <= s8_ad_a; hold_b8 <= s8_ad_b; hold_s8 <= s8_ad_sub;
    end
  end

  // ---------------- N = 4 instance ----------------
  logic s4_start, s4_done, s4_busy, s4_ad_start, s4_ad_sub;
  logic s4_ad_done = 1'b0;
  logic [3:0] s4_in_a, s4_in_b, s4_in_m;
  logic [3+EXTRA:0] s4_result;
  logic [5:0] s4_ad_a, s4_ad_b;
  logic [6:0] s4_ad_res = '0;
  logic [3:0] s4_state;

  mont_mul_ctrl #(.N(4)) u4 (
    .clk(clk), .reset(rst), .start(s4_start), .in_a(s4_in_a), .in_b(s4_in_b), .in_m(s4_in_m),
    .result(s4_result), .done(s4_done), .busy(s4_busy), .adder_start(s4_ad_start),
    .adder_subtract(s4_ad_sub), .adder_in_a(s4_ad_a), .adder_in_b(s4_ad_b),
    .adder_result(s4_ad_res), .adder_done(s4_ad_done), .state_dbg(s4_state));

  int cnt4 = 0, stab4 = 0, ovl4 = 0;
  logic [5:0] hold_a4, hold_b4;
  logic hold_s4;
  always @(posedge clk) begin
    s4_ad_done <= 1'b0;
    if (rst) cnt4 <= 0;
    else if (cnt4 > 0) begin
      if (s4_ad_a !== hold_a4 || s4_ad_b !== hold_b4 || s4_ad_sub !== hold_s4) stab4 <= stab4 + 1;
      if (s4_ad_start) ovl4 <= ovl4 + 1;
      if (cnt4 == 2) begin
        s4_ad_done <= 1'b1;
        s4_ad_res  <= s4_ad_sub ? ({1'b0, s4_ad_a} + {1'b0, ~s4_ad_b} + 7'd1)
                                : ({1'b0, s4_ad_a} + {1'b0, s4_ad_b});
      end
      cnt4 <= cnt4 - 1;
    end else if (s4_ad_start) begin
      cnt4 <= 3 + 1;
      hold_a4 <= s4_ad_a; hold_b4 <= s4_ad_b; hold_s4 <= s4_ad_sub;
    end
  end

  // ---------------- N = 512 instance ----------------
  logic s512_start, s512_done, s512_busy, s512_ad_start, s512_ad_sub;
  logic s512_ad_done = 1'b0;
  logic [511:0] s512_in_a, s512_in_b, s512_in_m;
  logic [511+EXTRA:0] s512_result;
  logic [513:0] s512_ad_a, s512_ad_b;
  logic [514:0] s512_ad_res = '0;
  logic [3:0] s512_state;

  mont_mul_ctrl #(.N(512)) u512 (
    .clk(clk), .reset(rst), .start(s512_start), .in_a(s512_in_a), .in_b(s512_in_b),
    .in_m(s512_in_m), .result(s512_result), .done(s512_done), .busy(s512_busy),
    .adder_start(s512_ad_start), .adder_subtract(s512_ad_sub), .adder_in_a(s512_ad_a),
    .adder_in_b(s512_ad_b), .adder_result(s512_ad_res), .adder_done(s512_ad_done),
    .state_dbg(s512_state));

  int cnt512 = 0, stab512 = 0, ovl512 = 0;
  logic [513:0] hold_a512, hold_b512;
  logic hold_s512;
  always @(posedge clk) begin
    s512_ad_done <= 1'b0;
    if (rst) cnt512 <= 0;
    else if (cnt512 > 0) begin
      if (s512_ad_a !== hold_a512 || s512_ad_b !== hold_b512 || s512_ad_sub !== hold_s512)
        stab512 <= stab512 + 1;
      if (s512_ad_start) ovl512 <= ovl512 + 1;
      if (cnt512 == 2) begin
        s512_ad_done <= 1'b1;
        s512_ad_res  <= s512_ad_sub ? ({1'b0, s512_ad_a} + {1'b0, ~s512_ad_b} + 515'd1)
                                    : ({1'b0, s512_ad_a} + {1'b0, s512_ad_b});
      end
      cnt512 <= cnt512 - 1;
    end else if (s512_ad_start) begin
      cnt512 <= 1 + 1;
      hold_a512 <= s512_ad_a; hold_b512 <= s512_ad_b; hold_s512 <= s512_ad_sub;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input big_t obs, input big_t expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // a*b*2^-512 mod m: reduce the product, then halve modulo the odd m 512 times.
  function automatic big_t mont_ref(input big_t a, input big_t b, input big_t m);
    big_t t;
    t = (a * b) % m;
    for (int i = 0; i < 512; i++) begin
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    return t;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                      output int ok, output logic [3:0] early);
    @(negedge clk);
    s8_in_a = a; s8_in_b = b; s8_in_m = m; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    ok = 0; early = '0;
    for (int k = 0; k < 2000 && ok == 0; k++) begin
      if (k < 4) early[k] = s8_ad_start;
      if (s8_done) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m, output int ok);
    @(negedge clk);
    s4_in_a = a; s4_in_b = b; s4_in_m = m; s4_start = 1'b1;
    @(negedge clk);
    s4_start = 1'b0;
    ok = 0;
    for (int k = 0; k < 1000 && ok == 0; k++) begin
      if (s4_done) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic run512(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                        output int ok);
    @(negedge clk);
    s512_in_a = a; s512_in_b = b; s512_in_m = m; s512_start = 1'b1;
    @(negedge clk);
    s512_start = 1'b0;
    ok = 0;
    for (int k = 0; k < 10000 && ok == 0; k++) begin
      if (s512_done) ok = 1;
      else @(negedge clk);
    end
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int ok;
    int s0;
    logic [3:0] early;
    logic [511:0] rm, ra, rb;
    big_t ma, aa, bb, expv, r;

    rst = 1'b1;
    s8_start = 1'b0; s4_start = 1'b0; s512_start = 1'b0;
    s8_in_a = '0; s8_in_b = '0; s8_in_m = '0;
    s4_in_a = '0; s4_in_b = '0; s4_in_m = '0;
    s512_in_a = '0; s512_in_b = '0; s512_in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_result", big_t'(s8_result), 0);
    check("rst_done", big_t'(s8_done), 0);
    check("rst_busy", big_t'(s8_busy), 0);
    check("rst_adder_start", big_t'(s8_ad_start), 0);
    check("rst_subtract", big_t'(s8_ad_sub), 0);
    check("rst_state", big_t'(s8_state), big_t'(S_IDLE));
    check("rst_result_n4", big_t'(s4_result), 0);
    check("rst_busy_n512", big_t'(s512_busy), 0);
    rst = 1'b0;

    // a=5, b=7, m=13: bit 0 of a is set, so the first adder call follows one ITER cycle.
    s0 = starts8;
    run8(8'd5, 8'd7, 8'd13, ok, early);
    check("a5b7_done", big_t'(ok), 1);
    check("a5b7_result", big_t'(s8_result), 1);
    check("a5b7_first_start", big_t'(early), 4'b0010);
    check("a5b7_starts", big_t'(starts8 - s0), 4 + SUB_EN);
    @(negedge clk);
    check("a5b7_done_pulse", big_t'(s8_done), 0);

    // a=12, b=12: iterations 0 and 1 skip, first adder_start in the fourth cycle.
    s0 = starts8;
    run8(8'd12, 8'd12, 8'd13, ok, early);
    check("a12b12_done", big_t'(ok), 1);
    check("a12b12_result", big_t'(s8_result), 3);
    check("a12b12_skip_timing", big_t'(early), 4'b1000);
    check("a12b12_starts", big_t'(starts8 - s0), 4 + SUB_EN);

    // N=4, m=15, a=b=14: raw C is 16, reduced to 1 only by the final subtraction.
    run4(4'd14, 4'd14, 4'd15, ok);
    check("n4_done", big_t'(ok), 1);
    check("n4_result", big_t'(s4_result), SUB_EN ? 1 : 16);

    // start pulsed during WAIT_B must be ignored.
    s0 = dones8;
    @(negedge clk);
    s8_in_a = 8'd5; s8_in_b = 8'd7; s8_in_m = 8'd13; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    ok = 0;
    for (int k = 0; k < 50 && ok == 0; k++) begin
      if (s8_ad_start) ok = 1;
      else @(negedge clk);
    end
    check("busy_first_add", big_t'(ok), 1);
    @(negedge clk);
    check("busy_in_wait_b", big_t'(s8_state), big_t'(S_WAIT_B));
    s8_in_a = 8'd12; s8_in_b = 8'd12; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    ok = 0;
    for (int k = 0; k < 2000 && ok == 0; k++) begin
      if (s8_done) ok = 1;
      else @(negedge clk);
    end
    check("busy_done", big_t'(ok), 1);
    check("busy_result", big_t'(s8_result), 1);
    repeat (30) @(negedge clk);
    check("busy_single_done", big_t'(dones8 - s0), 1);
    check("busy_idle_after", big_t'(s8_busy), 0);

    // reset asserted in WAIT_M aborts the operation.
    @(negedge clk);
    s8_in_a = 8'd5; s8_in_b = 8'd7; s8_in_m = 8'd13; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    ok = 0;
    for (int k = 0; k < 100 && ok == 0; k++) begin
      if (s8_state == S_WAIT_M) ok = 1;
      else @(negedge clk);
    end
    check("abort_reach_wait_m", big_t'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", big_t'(s8_result), 0);
    check("abort_done", big_t'(s8_done), 0);
    check("abort_busy", big_t'(s8_busy), 0);
    check("abort_adder_start", big_t'(s8_ad_start), 0);
    check("abort_subtract", big_t'(s8_ad_sub), 0);
    check("abort_state", big_t'(s8_state), big_t'(S_IDLE));
    run8(8'd5, 8'd7, 8'd13, ok, early);
    check("abort_rerun_done", big_t'(ok), 1);
    check("abort_rerun_result", big_t'(s8_result), 1);

    // Random 512-bit vectors against the arithmetic reference.
    for (int v = 0; v < 20; v++) begin
      for (int w = 0; w < 16; w++) begin
        rm[w*32 +: 32] = $urandom;
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rm[0] = 1'b1;
      rm[511] = 1'b1;
      ma = big_t'(rm);
      aa = big_t'(ra) % ma;
      bb = big_t'(rb) % ma;
      expv = mont_ref(aa, bb, ma);
      run512(aa[511:0], bb[511:0], ma[511:0], ok);
      check("rnd_done", big_t'(ok), 1);
      r = big_t'(s512_result);
      check("rnd_mod", r % ma, expv);
      check("rnd_range", big_t'(r < (SUB_EN ? ma : 2 * ma)), 1);
    end

    check("stable_n8", big_t'(stab8), 0);
    check("stable_n4", big_t'(stab4), 0);
    check("stable_n512", big_t'(stab512), 0);
    check("overlap_n8", big_t'(ovl8), 0);
    check("overlap_n4", big_t'(ovl4), 0);
    check("overlap_n512", big_t'(ovl512), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
